div_iter: RTL and testbench

Parametrised iterative integer divider for the execute stage. Implements the RISC-V M-extension DIV/DIVU/REM/REMU operations at any operand width using a restoring shift-subtract algorithm, one quotient bit per cycle. Compared with the fixed 32-bit divider it replaces, it adds:
- a one-shot start handshake instead of a held-high start;
- a synchronous flush input for pipeline squashes;
- explicit handling of signed overflow;
- an optional leading-zero skip that shortens latency for small dividends.

---
 rtl/div_iter.sv | 143 ++++++++++++++
 tb/tb_div_iter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider (RISC-V DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_ITER_SKIP_EN to skip the leading zeros of |dividend| and shorten latency.
module div_iter #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   dividend_i,
    input  logic [XLEN-1:0]   divisor_i,
    input  logic [REG_AW-1:0] reg_waddr_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic [XLEN-1:0]   result_o,
    output logic [REG_AW-1:0] reg_waddr_o
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic              is_signed, is_rem, neg_q, neg_r;
    logic [XLEN-1:0]   dvd;   // raw dividend, then magnitude; quotient bits enter at the LSB
    logic [XLEN-1:0]   dvs;
    logic [XLEN-1:0]   rem;
    logic [CW-1:0]     cnt;
    logic [REG_AW-1:0] waddr;

    logic            a_neg, b_neg, div_zero, ovf, prep_special, q_bit;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   rem_sh;

    assign a_neg    = is_signed & dvd[XLEN-1];
    assign b_neg    = is_signed & dvs[XLEN-1];
    assign abs_a    = a_neg ? -dvd : dvd;
    assign abs_b    = b_neg ? -dvs : dvs;
    assign div_zero = (dvs == '0);
    assign ovf      = is_signed && (dvd == {1'b1, {(XLEN-1){1'b0}}}) && (dvs == '1);

`ifdef DIV_ITER_SKIP_EN
    logic [CW-1:0] lz;
    always_comb begin
        lz = CW'(XLEN);
        for (int i = 0; i < XLEN; i++)
            if (abs_a[i]) lz = CW'(XLEN - 1 - i);
    end
    assign prep_special = div_zero | ovf | (abs_a == '0);
`else
    assign prep_special = div_zero | ovf;
`endif

    // One restoring step: partial remainder is XLEN+1 bits wide before the compare.
    assign rem_sh = {rem, dvd[XLEN-1]};
    assign q_bit  = (rem_sh >= {1'b0, dvs});

    assign busy_o  = (state != IDLE);
    assign ready_o = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: next state takes a default first so no path through the block infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = PREP;
            PREP:    state_nxt = prep_special ? FIX : CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    // NOTE: every datapath register, including result_o, is cleared by reset so no X escapes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_signed   <= 1'b0;
            is_rem      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            waddr       <= '0;
            result_o    <= '0;
            reg_waddr_o <= '0;
        end else if (!flush_i) begin
            case (state)
                IDLE: if (start_i) begin
                    dvd       <= dividend_i;
                    dvs       <= divisor_i;
                    waddr     <= reg_waddr_i;
                    is_signed <= (op_i == 3'b100) || (op_i == 3'b110);
                    is_rem    <= (op_i == 3'b110) || (op_i == 3'b111);
                end
                PREP: begin
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    dvs   <= abs_b;
                    rem   <= '0;
                    dvd   <= abs_a;
                    cnt   <= CW'(XLEN);
                    // Special results bypass sign correction: they are already final.
                    if (div_zero) begin
                        dvd   <= '1;
                        rem   <= dvd;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (ovf) begin
                        dvd   <= dvd;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end
`ifdef DIV_ITER_SKIP_EN
                    else begin
                        dvd <= abs_a << lz;
                        cnt <= CW'(XLEN) - lz;
                    end
`endif
                end
                CALC: begin
                    rem <= q_bit ? XLEN'(rem_sh - {1'b0, dvs}) : rem_sh[XLEN-1:0];
                    dvd <= {dvd[XLEN-2:0], q_bit};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    result_o    <= is_rem ? (neg_r ? -rem : rem) : (neg_q ? -dvd : dvd);
                    reg_waddr_o <= waddr;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and randomized checks of div_iter against an arithmetic reference model.
module tb_div_iter;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [2:0]      op_i = 3'b000;
    logic [XLEN-1:0] dividend_i = '0;
    logic [XLEN-1:0] divisor_i = '0;
    logic [AW-1:0]   reg_waddr_i = '0;
    logic            busy_o, ready_o;
    logic [XLEN-1:0] result_o;
    logic [AW-1:0]   reg_waddr_o;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] last_result = '0;

    div_iter #(.XLEN(XLEN), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i),
        .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o), .reg_waddr_o(reg_waddr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: RISC-V M-extension semantics with plain 64-bit arithmetic.
    function automatic logic [XLEN-1:0] ref_result(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        longint sa, sb;
        logic    ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'(sa / sb);
            3'b110:  return (b == 0) ? a : ov ? 32'h0 : 32'(sa % sb);
            3'b111:  return (b == 0) ? a : a % b;
            default: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        endcase
    endfunction

    // Edges from the accepting edge to the edge that starts the ready cycle.
    function automatic int ref_edges(input logic [2:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        logic            sgn;
        logic [XLEN-1:0] mag;
        int              n;
        sgn = (op == 3'b100) || (op == 3'b110);
        if (b == 0) return 2;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        mag = (sgn && a[XLEN-1]) ? -a : a;
        n = 0;
        while (mag != 0) begin
            n++;
            mag = mag >> 1;
        end
`ifdef DIV_ITER_SKIP_EN
        if (n == 0) return 2;
        return n + 2;
`else
        return XLEN + 2;
`endif
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [AW-1:0] wa, input int poke_at);
        logic [XLEN-1:0] exp_res;
        int              exp_edges, edges;
        bit              seen;
        exp_res   = ref_result(op, a, b);
        exp_edges = ref_edges(op, a, b);
        @(negedge clk);
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = wa;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("busy_after_accept", busy_o, 1);
        edges = 0;
        seen  = 0;
        while (!seen && edges < 200) begin
            if (edges == poke_at) begin
                start_i = 1'b1; op_i = 3'b100; dividend_i = 32'h1234; divisor_i = 32'h3;
                reg_waddr_i = ~wa;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            edges++;
            if (ready_o) seen = 1;
        end
        check("ready_seen", seen, 1);
        check("latency_edges", edges, exp_edges);
        check("result", result_o, exp_res);
        check("waddr", reg_waddr_o, wa);
        check("busy_in_ready", busy_o, 1);
        last_result = exp_res;
        @(posedge clk); #1;
        check("busy_after_ready", busy_o, 0);
        check("ready_single", ready_o, 0);
        check("result_held", result_o, exp_res);
    endtask

    initial begin
        int pulses;
        logic [XLEN-1:0] a, b;

        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_ready", ready_o, 0);
        check("rst_result", result_o, 0);
        check("rst_waddr", reg_waddr_o, 0);
        rst = 1'b1;

        do_op(3'b100, 32'hFFFF_FFF9, 32'h2, 5'd1, -1);
        do_op(3'b110, 32'hFFFF_FFF9, 32'h2, 5'd2, -1);
        do_op(3'b101, 32'h64, 32'h0, 5'd3, -1);
        do_op(3'b111, 32'h64, 32'h0, 5'd4, -1);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, -1);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, -1);
        do_op(3'b101, 32'hFFFF_FFFF, 32'h10, 5'd7, 10);
        do_op(3'b101, 32'd5, 32'd2, 5'd8, -1);
        do_op(3'b100, 32'h0, 32'h7, 5'd9, -1);

        // Flush on the tenth CALC cycle.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b101; dividend_i = 32'h1234_5678; divisor_i = 32'd7; reg_waddr_i = 5'd20;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_busy", busy_o, 0);
        check("flush_ready", ready_o, 0);
        check("flush_result", result_o, last_result);
        pulses = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (ready_o) pulses++;
        end
        check("flush_no_ready", pulses, 0);
        check("flush_result_kept", result_o, last_result);

        // Flush together with start in IDLE: request refused.
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        check("flush_start_busy", busy_o, 0);
        @(posedge clk); #1;
        check("flush_start_idle", busy_o, 0);

        do_op(3'b101, 32'd9, 32'd3, 5'd11, -1);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 300);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_op(3'($urandom_range(0, 7)), a, b, 5'($urandom), -1);
        end

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b100; dividend_i = 32'hDEAD_BEEF; divisor_i = 32'd3; reg_waddr_i = 5'd30;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_ready", ready_o, 0);
        check("arst_result", result_o, 0);
        check("arst_waddr", reg_waddr_o, 0);
        @(negedge clk);
        rst = 1'b1;
        do_op(3'b111, 32'd100, 32'd7, 5'd12, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
